fp_thresh_sched: RTL and testbench
==================================

# fp_thresh_sched

Sequencer that time-shares one `fp_gt` comparator to classify a 32-bit IEEE-754 indicator sample, for example RSI, against a programmable low/high threshold pair. It replaces two parallel comparators with one comparator plus a small FSM. It accepts samples over a valid/ready handshake and returns a registered decision over a second valid/ready handshake. It sits between the indicator datapath and the order-decision logic in generated strategy designs.

## Interface
- No parameters; widths are fixed at 32-bit single precision.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: sample offered.
- `in_ready` out 1: block can accept a sample; high only in IDLE.
- `in_data` in 32: float32 sample.
- `cfg_we` in 1: threshold write strobe.
- `cfg_sel` in 1: write target; 0 = low threshold, 1 = high threshold.
- `cfg_data` in 32: float32 threshold value.
- `out_valid` out 1: decision available.
- `out_ready` in 1: consumer accepts the decision.
- `out_hold` out 1: decision bit 1 (neutral).
- `out_below` out 1: decision bit 0 (sample below low threshold).

## Operation
- Decision encoding, as `{out_hold, out_below}`:
  - ABOVE = 2'b00 when `sample > high`. ABOVE has priority.
  - BELOW = 2'b01 when `low > sample`.
  - HOLD = 2'b10 otherwise.
- Comparison semantics, including equality and NaN, are whatever `fp_gt` defines. Equality to either threshold yields HOLD.
- Threshold registers reset to low = 0x41F00000 (30.0) and high = 0x428C0000 (70.0).
- `cfg_we` writes are accepted in any state.
- On sample acceptance, the sample and both thresholds are snapshotted. A write in flight affects only later samples. A write in the same cycle as acceptance is not seen by that sample.
- FSM states:
  - IDLE: `in_ready`=1. Goes to CMP_HI on `in_valid`.
  - CMP_HI: comparator inputs are `f1`=sample, `f2`=high; result is registered to `hi_flag`. Goes to CMP_LO, or to DONE when early exit applies (see Configuration).
  - CMP_LO: comparator inputs are `f1`=low, `f2`=sample; result is registered to `lo_flag`. Goes to DONE.
  - DONE: `out_valid`=1 and the decision is driven from the flags. Goes to IDLE on `out_ready`; otherwise holds with outputs stable.
- The comparator input mux is driven only by state. Outside CMP_HI and CMP_LO it selects the CMP_HI inputs, and its result is ignored.
- Output reset values: `in_ready`=0 during reset and 1 from the first cycle after it; `out_valid`=0; `out_hold`=1; `out_below`=0. The HOLD encoding is presented whenever `out_valid`=0.
- Reset mid-operation aborts the evaluation, returns the FSM to IDLE, discards the flags and restores the default thresholds. No decision is emitted for the aborted sample.

## Timing
- Accept edge is T0. State is CMP_HI at T0+1 and CMP_LO at T0+2.
- `out_valid` rises at T0+3, giving a latency of 3 cycles. With early exit and a high hit, it rises at T0+2.
- Handshake edge is the cycle where `out_valid && out_ready`. `in_ready`=1 in the following cycle.
- Maximum throughput is one sample every 4 cycles, or 3 with an early exit.
- `in_ready` is a registered decode of the state. It carries no combinational path from `out_ready`.

## Configuration
- Macro: `FP_THRESH_SCHED_EARLY_EXIT_EN`.
- Defined: if `hi_flag` is set in CMP_HI, go directly to DONE and skip CMP_LO. Latency is variable (2 or 3 cycles).
- Undefined: CMP_LO always runs and latency is a fixed 3 cycles. The decision is identical in both builds.

## Structure
- Package `fp_thresh_pkg` holds:
  - the state enum;
  - decision localparams DEC_ABOVE, DEC_BELOW, DEC_HOLD;
  - DEFAULT_LOW and DEFAULT_HIGH bit patterns.
- One sub-module instance: the existing `fp_gt`, instantiated exactly once. No new sub-module is needed.

## Test plan
- Reset, then send 50.0 (0x42480000) -> HOLD (2'b10) with `out_valid` at T0+3.
- Send 80.0 (0x42A00000) -> ABOVE (2'b00). Latency is 2 with the macro defined and 3 without it.
- Send 20.0 (0x41A00000) -> BELOW (2'b01). Then send exactly 70.0 (0x428C0000) -> HOLD.
- Hold `out_ready`=0 for 5 cycles on a BELOW result -> `out_valid` and the decision stay stable and `in_ready` stays 0. One cycle after `out_ready` is raised, `in_ready`=1.
- Write high=40.0 (0x42200000) in the same cycle as accepting 50.0 -> that sample gives HOLD. A following 50.0 gives ABOVE.
- Assert `rst` in CMP_LO -> no `out_valid`. The next 50.0 is classified against restored defaults and gives HOLD.

Source files
------------

// File: rtl/fp_thresh_pkg.sv
// Shared types and constants for the fp_thresh_sched threshold classifier.
package fp_thresh_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMP_HI = 2'd1,
    CMP_LO = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Decision encoding as {out_hold, out_below}.
  localparam logic [1:0] DEC_ABOVE = 2'b00;
  localparam logic [1:0] DEC_BELOW = 2'b01;
  localparam logic [1:0] DEC_HOLD  = 2'b10;

  localparam logic [31:0] DEFAULT_LOW  = 32'h41F0_0000; // 30.0
  localparam logic [31:0] DEFAULT_HIGH = 32'h428C_0000; // 70.0

endpackage

// File: rtl/fp_gt.sv
// Combinational float32 ordered greater-than: gt = (f1 > f2).
// NaN on either side gives 0; +0 and -0 compare equal.
module fp_gt (
  input  logic [31:0] f1,
  input  logic [31:0] f2,
  output logic        gt
);

  logic nan1;
  logic nan2;
  logic both_zero;

  assign nan1      = (f1[30:23] == 8'hFF) && (f1[22:0] != 23'd0);
  assign nan2      = (f2[30:23] == 8'hFF) && (f2[22:0] != 23'd0);
  assign both_zero = (f1[30:0] == 31'd0) && (f2[30:0] == 31'd0);

  always_comb begin
    gt = 1'b0;
    if (!nan1 && !nan2 && !both_zero) begin
      if (f1[31] != f2[31])
        gt = !f1[31];
      else if (!f1[31])
        gt = f1[30:0] > f2[30:0];
      else
        gt = f1[30:0] < f2[30:0];
    end
  end

endmodule

// File: rtl/fp_thresh_sched.sv
// Classifies a float32 sample against low/high thresholds using one shared fp_gt.
// Latency 3 (2 on a high hit when FP_THRESH_SCHED_EARLY_EXIT_EN); stalls in DONE until out_ready.
module fp_thresh_sched
  import fp_thresh_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        cfg_we,
  input  logic        cfg_sel,
  input  logic [31:0] cfg_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_hold,
  output logic        out_below
);

  state_t      state;
  logic [31:0] thr_low;
  logic [31:0] thr_high;
  logic [31:0] sample;
  logic [31:0] snap_low;
  logic [31:0] snap_high;
  logic        hi_flag;
  logic        lo_flag;
  logic [31:0] cmp_a;
  logic [31:0] cmp_b;
  logic        cmp_gt;

  always_ff @(posedge clk) begin
    if (rst) begin
      thr_low  <= DEFAULT_LOW;
      thr_high <= DEFAULT_HIGH;
    end else if (cfg_we) begin
      if (cfg_sel)
        thr_high <= cfg_data;
      else
        thr_low <= cfg_data;
    end
  end

  // Only CMP_LO swaps the operands; every other state presents the CMP_HI pair.
  assign cmp_a = (state == CMP_LO) ? snap_low : sample;
  assign cmp_b = (state == CMP_LO) ? sample   : snap_high;

  fp_gt u_fp_gt (
    .f1 (cmp_a),
    .f2 (cmp_b),
    .gt (cmp_gt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      hi_flag   <= 1'b0;
      lo_flag   <= 1'b0;
      sample    <= 32'd0;
      snap_low  <= DEFAULT_LOW;
      snap_high <= DEFAULT_HIGH;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            sample    <= in_data;
            snap_low  <= thr_low;
            snap_high <= thr_high;
            hi_flag   <= 1'b0;
            lo_flag   <= 1'b0;
            in_ready  <= 1'b0;
            state     <= CMP_HI;
          end
        end
        CMP_HI: begin
          hi_flag <= cmp_gt;
`ifdef FP_THRESH_SCHED_EARLY_EXIT_EN
          if (cmp_gt) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            state <= CMP_LO;
          end
`else
          state <= CMP_LO;
`endif
        end
        CMP_LO: begin
          lo_flag   <= cmp_gt;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Decision decodes registered flags only; HOLD whenever nothing is valid.
  assign out_hold  = !out_valid || (!hi_flag && !lo_flag);
  assign out_below = out_valid && !hi_flag && lo_flag;

endmodule

// File: tb/tb_fp_thresh_sched.sv
// Directed bench for fp_thresh_sched: decisions, latency, stall, config snapshot, reset abort.
module tb_fp_thresh_sched;

  localparam logic [31:0] F20 = 32'h41A0_0000;
  localparam logic [31:0] F40 = 32'h4220_0000;
  localparam logic [31:0] F50 = 32'h4248_0000;
  localparam logic [31:0] F70 = 32'h428C_0000;
  localparam logic [31:0] F80 = 32'h42A0_0000;
`ifdef FP_THRESH_SCHED_EARLY_EXIT_EN
  localparam int ABOVE_LAT = 2;
`else
  localparam int ABOVE_LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        cfg_we;
  logic        cfg_sel;
  logic [31:0] cfg_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_hold;
  logic        out_below;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fp_thresh_sched dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_data  (cfg_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_hold  (out_hold),
    .out_below (out_below)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one sample (optionally with a same-cycle high-threshold write) and
  // returns the cycle index at which out_valid is seen; acceptance cycle is 0.
  task automatic send(input logic [31:0] d, input logic wr, input logic [31:0] wv, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    in_valid = 1'b1;
    in_data  = d;
    cfg_we   = wr;
    cfg_sel  = 1'b1;
    cfg_data = wv;
    tick();
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      tick();
      lat++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({in_ready, out_valid, out_hold, out_below} !== 4'b0010) begin
      errs++;
      $display("FAIL reset_outputs got {rdy,vld,hold,below}=%b expected 0010",
               {in_ready, out_valid, out_hold, out_below});
    end
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset_in_ready got %b expected 1", in_ready);
    end
  endtask

  task automatic test_hold();
    int lat;
    send(F50, 1'b0, 32'd0, lat);
    checks++;
    if (lat != 3) begin
      errs++;
      $display("FAIL hold_latency got %0d expected 3", lat);
    end
    checks++;
    if ({out_hold, out_below} !== 2'b10) begin
      errs++;
      $display("FAIL hold_decision got %b expected 10", {out_hold, out_below});
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errs++;
      $display("FAIL hold_in_ready_busy got %b expected 0", in_ready);
    end
    take();
    checks++;
    if ({in_ready, out_valid, out_hold, out_below} !== 4'b1010) begin
      errs++;
      $display("FAIL hold_after_handshake got {rdy,vld,hold,below}=%b expected 1010",
               {in_ready, out_valid, out_hold, out_below});
    end
  endtask

  task automatic test_above();
    int lat;
    send(F80, 1'b0, 32'd0, lat);
    checks++;
    if (lat != ABOVE_LAT) begin
      errs++;
      $display("FAIL above_latency got %0d expected %0d", lat, ABOVE_LAT);
    end
    checks++;
    if ({out_valid, out_hold, out_below} !== 3'b100) begin
      errs++;
      $display("FAIL above_decision got {vld,hold,below}=%b expected 100",
               {out_valid, out_hold, out_below});
    end
    take();
  endtask

  task automatic test_below_equal();
    int lat;
    send(F20, 1'b0, 32'd0, lat);
    checks++;
    if (lat != 3 || {out_hold, out_below} !== 2'b01) begin
      errs++;
      $display("FAIL below_decision got lat=%0d dec=%b expected lat=3 dec=01",
               lat, {out_hold, out_below});
    end
    take();
    send(F70, 1'b0, 32'd0, lat);
    checks++;
    if (lat != 3 || {out_hold, out_below} !== 2'b10) begin
      errs++;
      $display("FAIL equal_high_decision got lat=%0d dec=%b expected lat=3 dec=10",
               lat, {out_hold, out_below});
    end
    take();
  endtask

  task automatic test_stall();
    int lat;
    send(F20, 1'b0, 32'd0, lat);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({out_valid, out_hold, out_below, in_ready} !== 4'b1010) begin
        errs++;
        $display("FAIL stall_cycle%0d got {vld,hold,below,rdy}=%b expected 1010",
                 i, {out_valid, out_hold, out_below, in_ready});
      end
    end
    take();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errs++;
      $display("FAIL stall_release got rdy=%b vld=%b expected rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_cfg_same_cycle();
    int lat;
    send(F50, 1'b1, F40, lat);
    checks++;
    if ({out_valid, out_hold, out_below} !== 3'b110) begin
      errs++;
      $display("FAIL cfg_same_cycle got {vld,hold,below}=%b expected 110",
               {out_valid, out_hold, out_below});
    end
    take();
    send(F50, 1'b0, 32'd0, lat);
    checks++;
    if ({out_valid, out_hold, out_below} !== 3'b100 || lat != ABOVE_LAT) begin
      errs++;
      $display("FAIL cfg_next_sample got {vld,hold,below}=%b lat=%0d expected 100 lat=%0d",
               {out_valid, out_hold, out_below}, lat, ABOVE_LAT);
    end
    take();
  endtask

  task automatic test_reset_abort();
    int lat;
    logic seen;
    in_valid = 1'b1;
    in_data  = F20;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin
      errs++;
      $display("FAIL abort_no_output got out_valid seen=%b expected 0", seen);
    end
    send(F50, 1'b0, 32'd0, lat);
    checks++;
    if (lat != 3 || {out_valid, out_hold, out_below} !== 3'b110) begin
      errs++;
      $display("FAIL abort_defaults got lat=%0d {vld,hold,below}=%b expected lat=3 110",
               lat, {out_valid, out_hold, out_below});
    end
    take();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    cfg_we    = 1'b0;
    cfg_sel   = 1'b0;
    cfg_data  = 32'd0;
    out_ready = 1'b0;
    test_reset();
    test_hold();
    test_above();
    test_below_equal();
    test_stall();
    test_cfg_same_cycle();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
